serial_full_subtractor: RTL and testbench
=========================================

// Module: serial_full_subtractor
// PURPOSE
//   Bit-serial N-bit subtractor: diff = a - b - borrow_in, computed LSB-first.
//   One full-subtractor cell plus a borrow flip-flop handles one bit per clock.
//   Counterpart to the full-adder datapath: the subtract direction, area-cheap.
//   Operands enter and the result leaves through valid/ready handshakes.
// PARAMETERS
//   WIDTH  8  operand/result width in bits (>=1)
// PORTS
//   clk        in   1      single clock, all logic on rising edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      operands a/b/borrow_in valid
//   in_ready   out  1      block can accept operands (IDLE only)
//   a          in   WIDTH  minuend
//   b          in   WIDTH  subtrahend
//   borrow_in  in   1      initial borrow into bit 0
//   out_valid  out  1      diff/borrow_out valid
//   out_ready  in   1      consumer accepts result
//   diff       out  WIDTH  a - b - borrow_in (mod 2^WIDTH)
//   borrow_out out  1      final borrow from bit WIDTH-1 (1 = a < b + borrow_in, unsigned)
//   busy       out  1      high in SHIFT and DONE
// BEHAVIOUR
//   Reset (rst=1 at clk edge): state=IDLE, in_ready=1, out_valid=0, busy=0,
//     diff=0, borrow_out=0, bit counter=0, borrow FF=0. Reset wins over any other event.
//   Cell: d = a_i ^ b_i ^ bw; bo = (~a_i & b_i) | (~(a_i ^ b_i) & bw).
//   FSM IDLE -> SHIFT: on in_valid && in_ready. Latch a, b into shift regs;
//     borrow FF <= borrow_in; counter <= 0.
//   SHIFT: each cycle, compute d/bo on the shift-reg LSBs. Shift d into diff at
//     MSB (right shift). borrow FF <= bo. Counter++.
//   SHIFT -> DONE: after exactly WIDTH SHIFT cycles. borrow_out <= last bo.
//   DONE: out_valid=1. diff and borrow_out hold stable until out_ready=1.
//   DONE -> IDLE: on out_valid && out_ready. out_valid drops the next cycle.
//   Latency: acceptance edge to first out_valid cycle = WIDTH+1 clocks.
//   Throughput: one operation per WIDTH+2 clocks when out_ready is held high.
//   in_ready=0 in SHIFT and DONE. in_valid there is ignored, no queuing.
//     Operand changes after acceptance have no effect.
//   No same-cycle accept in DONE; a new operation is accepted the cycle after IDLE is entered.
//   WIDTH=1: one SHIFT cycle, then DONE.
//   Reset mid-SHIFT or in DONE: in-flight result discarded, IDLE next cycle.
// CONFIGURATION
//   SERIAL_SUB_OVF_EN defined: adds output port overflow (1 bit, reset 0).
//     Valid with out_valid; set when a and b are treated as two's-complement, i.e.
//     overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).
//     Operand MSBs are captured at acceptance.
//   SERIAL_SUB_OVF_EN undefined: port and logic absent, all other behaviour identical.
// TESTING (WIDTH=8 unless noted)
//   a=0x05, b=0x03, borrow_in=0 -> diff=0x02, borrow_out=0; out_valid exactly 9 clocks after accept.
//   a=0x03, b=0x05, borrow_in=0 -> diff=0xFE, borrow_out=1.
//   a=0x00, b=0x00, borrow_in=1 -> diff=0xFF, borrow_out=1. a=0xFF, b=0xFF, borrow_in=0 -> 0x00, 0.
//   Result in DONE, out_ready=0 for 5 clocks -> out_valid, diff, borrow_out stable.
//     in_ready stays 0 and in_valid is ignored; out_ready=1 -> IDLE next cycle.
//   rst pulse on 3rd SHIFT cycle -> next cycle in_ready=1, out_valid=0, diff=0.
//     Next operation 0x10-0x01 -> 0x0F.
//   SERIAL_SUB_OVF_EN: 0x80-0x01 -> diff=0x7F, overflow=1; 0x7F-0xFF -> diff=0x80, overflow=1; 0x05-0x03 -> overflow=0.
//   WIDTH=1: all 8 (a, b, borrow_in) combos -> full-subtractor truth table; latency 2 clocks.

Source files
------------

// File: rtl/serial_full_subtractor.sv
// serial_full_subtractor
//   Bit-serial subtractor: diff = a - b - borrow_in (mod 2^WIDTH), LSB first.
//   One full-subtractor cell and a borrow flop process one bit per clock.
//   Operands enter through a valid/ready handshake, and the result leaves through one.
//
// Parameters
//   WIDTH       operand/result width (>=1)
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   in_valid    operands valid          in_ready   accepting (IDLE only)
//   a, b        minuend / subtrahend    borrow_in  borrow into bit 0
//   out_valid   result valid            out_ready  consumer accepts result
//   diff        a - b - borrow_in       borrow_out final borrow (unsigned a < b+bin)
//   busy        high in SHIFT and DONE
//   overflow    (only with SERIAL_SUB_OVF_EN) two's-complement overflow,
//               valid with out_valid
//
// Build option: define SERIAL_SUB_OVF_EN to add the overflow output.
module serial_full_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
`ifdef SERIAL_SUB_OVF_EN
  output logic             overflow,
`endif
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [CW-1:0]    cnt;
  logic             bw;

`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb, b_msb;
`endif

  // Full-subtractor cell on the current LSBs
  logic             d, bo, last;
  logic [WIDTH-1:0] diff_nxt;

  always_comb begin
    d    = a_sh[0] ^ b_sh[0] ^ bw;
    bo   = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & bw);
    last = (cnt == CW'(WIDTH - 1));
    // Result bits arrive LSB first, so enter at the MSB and shift right;
    // after WIDTH shifts bit 0 has reached position 0.
    diff_nxt            = diff >> 1;
    diff_nxt[WIDTH-1]   = d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      cnt        <= '0;
      bw         <= 1'b0;
      a_sh       <= '0;
      b_sh       <= '0;
`ifdef SERIAL_SUB_OVF_EN
      overflow   <= 1'b0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            state    <= SHIFT;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            a_sh     <= a;
            b_sh     <= b;
            bw       <= borrow_in;
            cnt      <= '0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb    <= a[WIDTH-1];
            b_msb    <= b[WIDTH-1];
`endif
          end
        end
        SHIFT: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          bw   <= bo;
          diff <= diff_nxt;
          cnt  <= cnt + 1'b1;
          if (last) begin
            state      <= DONE;
            out_valid  <= 1'b1;
            borrow_out <= bo;
`ifdef SERIAL_SUB_OVF_EN
            // d is the result MSB produced this cycle
            overflow   <= (a_msb ^ b_msb) & (d ^ a_msb);
`endif
          end
        end
        DONE: begin
          // Result holds until taken; no accept in the same cycle.
          if (out_valid && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_full_subtractor.sv
// Directed bench for serial_full_subtractor: WIDTH=8 instance plus a WIDTH=1
// instance for the truth table.
module tb_serial_full_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  int         checks   = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       in_valid, in_ready, out_valid, out_ready, borrow_in, borrow_out, busy;
  logic [7:0] a, b, diff;
`ifdef SERIAL_SUB_OVF_EN
  logic       overflow;
`endif

  serial_full_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .borrow_in(borrow_in), .out_valid(out_valid),
    .out_ready(out_ready), .diff(diff), .borrow_out(borrow_out),
`ifdef SERIAL_SUB_OVF_EN
    .overflow(overflow),
`endif
    .busy(busy)
  );

  // WIDTH=1 instance
  logic       in_valid1, in_ready1, out_valid1, out_ready1, borrow_in1, borrow_out1, busy1;
  logic [0:0] a1, b1, diff1;
`ifdef SERIAL_SUB_OVF_EN
  logic       overflow1;
`endif

  serial_full_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .borrow_in(borrow_in1), .out_valid(out_valid1),
    .out_ready(out_ready1), .diff(diff1), .borrow_out(borrow_out1),
`ifdef SERIAL_SUB_OVF_EN
    .overflow(overflow1),
`endif
    .busy(busy1)
  );

  // Drive one operation on the WIDTH=8 instance and take the result.
  // lat = clocks from accept cycle to first out_valid cycle (-1 on timeout).
  task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic bin,
                      output int lat, output logic [7:0] d, output logic bo,
                      output logic ov);
    @(negedge clk);
    a = av; b = bv; borrow_in = bin; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; a = 8'hAA; b = 8'h55;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) lat = -1;
    d = diff; bo = borrow_out;
`ifdef SERIAL_SUB_OVF_EN
    ov = overflow;
`else
    ov = 1'b0;
`endif
    @(posedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
        diff !== 8'h00 || borrow_out !== 1'b0) begin
      failures++;
      $display("FAIL reset: in_ready=%b out_valid=%b busy=%b diff=%h bo=%b, want 1 0 0 00 0",
               in_ready, out_valid, busy, diff, borrow_out);
    end
    rst = 1'b0;
  endtask

  task automatic test_vectors;
    logic [7:0] av [4] = '{8'h05, 8'h03, 8'h00, 8'hFF};
    logic [7:0] bv [4] = '{8'h03, 8'h05, 8'h00, 8'hFF};
    logic       bi [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] ed [4] = '{8'h02, 8'hFE, 8'hFF, 8'h00};
    logic       eb [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    int lat; logic [7:0] d; logic bo, ov;
    for (int i = 0; i < 4; i++) begin
      run8(av[i], bv[i], bi[i], lat, d, bo, ov);
      checks++;
      if (d !== ed[i] || bo !== eb[i]) begin
        failures++;
        $display("FAIL vec%0d: diff=%h bo=%b, want %h %b", i, d, bo, ed[i], eb[i]);
      end
      checks++;
      if (lat !== 9) begin
        failures++;
        $display("FAIL latency%0d: got %0d want 9", i, lat);
      end
    end
    // back in IDLE the cycle after the handshake
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL post_handshake: in_ready=%b out_valid=%b busy=%b, want 1 0 0",
               in_ready, out_valid, busy);
    end
  endtask

  task automatic test_hold;
    logic [7:0] d0; logic bo0; int n;
    @(negedge clk);
    a = 8'h20; b = 8'h31; borrow_in = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    // keep offering other operands; they must be ignored
    a = 8'h77; b = 8'h11;
    n = 0;
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (!out_valid) begin
      failures++;
      $display("FAIL hold_timeout: out_valid never rose");
    end
    d0 = diff; bo0 = borrow_out;
    checks++;
    if (d0 !== 8'hEF || bo0 !== 1'b1) begin
      failures++;
      $display("FAIL hold_value: diff=%h bo=%b, want ef 1", d0, bo0);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || diff !== 8'hEF || borrow_out !== 1'b1 ||
          in_ready !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL hold_stable%0d: ov=%b diff=%h bo=%b in_ready=%b busy=%b, want 1 ef 1 0 1",
                 i, out_valid, diff, borrow_out, in_ready, busy);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL hold_release: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid;
    int lat; logic [7:0] d; logic bo, ov;
    @(negedge clk);
    a = 8'h44; b = 8'h12; borrow_in = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);          // SHIFT cycle 1
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL shift_flags: busy=%b in_ready=%b, want 1 0", busy, in_ready);
    end
    @(negedge clk);          // SHIFT cycle 2
    @(negedge clk);          // SHIFT cycle 3
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 8'h00 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: in_ready=%b out_valid=%b diff=%h busy=%b, want 1 0 00 0",
               in_ready, out_valid, diff, busy);
    end
    run8(8'h10, 8'h01, 1'b0, lat, d, bo, ov);
    checks++;
    if (d !== 8'h0F || bo !== 1'b0 || lat !== 9) begin
      failures++;
      $display("FAIL after_reset_op: diff=%h bo=%b lat=%0d, want 0f 0 9", d, bo, lat);
    end
  endtask

`ifdef SERIAL_SUB_OVF_EN
  task automatic test_overflow;
    logic [7:0] av [3] = '{8'h80, 8'h7F, 8'h05};
    logic [7:0] bv [3] = '{8'h01, 8'hFF, 8'h03};
    logic [7:0] ed [3] = '{8'h7F, 8'h80, 8'h02};
    logic       eo [3] = '{1'b1, 1'b1, 1'b0};
    int lat; logic [7:0] d; logic bo, ov;
    for (int i = 0; i < 3; i++) begin
      run8(av[i], bv[i], 1'b0, lat, d, bo, ov);
      checks++;
      if (d !== ed[i] || ov !== eo[i]) begin
        failures++;
        $display("FAIL ovf%0d: diff=%h ovf=%b, want %h %b", i, d, ov, ed[i], eo[i]);
      end
    end
  endtask
`endif

  task automatic test_width1;
    // {diff, borrow_out} indexed by {a, b, borrow_in}
    logic [1:0] exp1 [8] = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};
    logic [2:0] v;
    int lat;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      @(negedge clk);
      a1 = v[2]; b1 = v[1]; borrow_in1 = v[0]; in_valid1 = 1'b1; out_ready1 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid1 = 1'b0;
      lat = 1;
      while (!out_valid1 && lat < 10) begin @(negedge clk); lat++; end
      checks++;
      if ({diff1[0], borrow_out1} !== exp1[i] || lat !== 2) begin
        failures++;
        $display("FAIL w1_%0d: d/bo=%b%b lat=%0d, want %b lat 2",
                 i, diff1[0], borrow_out1, lat, exp1[i]);
      end
      @(posedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; borrow_in = 1'b0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0; borrow_in1 = 1'b0;
    test_reset;
    test_vectors;
    test_hold;
    test_reset_mid;
`ifdef SERIAL_SUB_OVF_EN
    test_overflow;
`endif
    test_width1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
